// File: rtl/btn_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | btn_conditioner: per-channel synchroniser, debouncer, edge pulses,          |
// | auto-repeat and sticky pending-event flag.                                  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module btn_conditioner #(
  parameter int N_CH      = 2,
  parameter int DB_CYCLES = 50000,
  parameter int RPT_DELAY = 500000,
  parameter int RPT_RATE  = 100000,
  parameter int CNT_W     = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] rpt_en,
  input  logic [N_CH-1:0] evt_ack,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat,
  output logic [N_CH-1:0] evt_pend
);

  localparam longint c_max_span = (DB_CYCLES > RPT_DELAY) ? longint'(DB_CYCLES) : longint'(RPT_DELAY);
  localparam longint c_cnt_span = longint'(1) << CNT_W;

  localparam logic [CNT_W-1:0] c_db_last    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_delay_last = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_rate_last  = CNT_W'(RPT_RATE - 1);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;

  if ((c_cnt_span <= c_max_span) || (N_CH < 1) || (N_CH > 8) ||
      (DB_CYCLES < 2) || (RPT_RATE < 1) || (RPT_RATE > RPT_DELAY)) begin : g_bad_cfg
    $error("btn_conditioner: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RATE  = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             r_sync1, r_sync2, r_level;
    logic             r_press, r_release, r_repeat, r_pend;
    logic [CNT_W-1:0] r_db_cnt, r_rpt_cnt;
    rpt_state_t       r_state;

    logic             w_level_nxt, w_press_nxt, w_release_nxt, w_repeat_nxt, w_pend_nxt;
    logic [CNT_W-1:0] w_db_cnt_nxt, w_rpt_cnt_nxt;
    rpt_state_t       w_state_nxt;

    // Debounce: accept sync2 once it has disagreed with the level DB_CYCLES cycles in a row
    always_comb begin
      w_db_cnt_nxt  = '0;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      if (r_sync2 != r_level) begin
        if (r_db_cnt == c_db_last) begin
          w_level_nxt   = r_sync2;
          w_press_nxt   = r_sync2;
          w_release_nxt = !r_sync2;
        end else if (r_db_cnt != c_cnt_max) begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt;
        end
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_rpt_cnt_nxt = r_rpt_cnt;
      w_repeat_nxt  = 1'b0;
      if (w_press_nxt) begin
        w_state_nxt   = ST_DELAY;
        w_rpt_cnt_nxt = '0;
      end else if (w_release_nxt) begin
        w_state_nxt   = ST_IDLE;
        w_rpt_cnt_nxt = '0;
      end else if (r_level && rpt_en[i]) begin
        case (r_state)
          ST_DELAY: begin
            if (r_rpt_cnt == c_delay_last) begin
              w_repeat_nxt  = 1'b1;
              w_rpt_cnt_nxt = '0;
              w_state_nxt   = ST_RATE;
            end else if (r_rpt_cnt != c_cnt_max) begin
              w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
            end
          end
          ST_RATE: begin
            if (r_rpt_cnt == c_rate_last) begin
              w_repeat_nxt  = 1'b1;
              w_rpt_cnt_nxt = '0;
            end else if (r_rpt_cnt != c_cnt_max) begin
              w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Pend is set from the visible pulses, so an ack in the pulse cycle loses to the set
    assign w_pend_nxt = r_press | r_repeat | (r_pend & ~evt_ack[i]);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_level   <= 1'b0;
        r_db_cnt  <= '0;
        r_rpt_cnt <= '0;
        r_state   <= ST_IDLE;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
        r_pend    <= 1'b0;
      end else if (ena) begin
        r_sync1   <= btn_in[i];
        r_sync2   <= r_sync1;
        r_level   <= w_level_nxt;
        r_db_cnt  <= w_db_cnt_nxt;
        r_rpt_cnt <= w_rpt_cnt_nxt;
        r_state   <= w_state_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_repeat  <= w_repeat_nxt;
        r_pend    <= w_pend_nxt;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
      end
    end

    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press & ena;
    assign btn_release[i] = r_release & ena;
    assign btn_repeat[i]  = r_repeat & ena;
    assign evt_pend[i]    = r_pend;
  end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_CH, default 2: number of independent button channels (ch0 = up, ch1 = down); range 1..8.
REQ-002 Parameter DB_CYCLES, default 50000: cycles a synchronised input must differ from the stable level before it is accepted; minimum 2.
REQ-003 Parameter RPT_DELAY, default 500000: cycles from a press pulse to the first repeat pulse.
REQ-004 Parameter RPT_RATE, default 100000: cycles between subsequent repeat pulses; RPT_RATE <= RPT_DELAY.
REQ-005 Parameter CNT_W, default 20: counter width; elaboration SHALL fail if 2**CNT_W <= max(DB_CYCLES, RPT_DELAY).
REQ-006 clk  in  1  single design clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 ena  in  1  block enable; low freezes all state.
REQ-009 btn_in  in  N_CH  raw asynchronous button levels, active-high.
REQ-010 rpt_en  in  N_CH  per-channel auto-repeat enable.
REQ-011 evt_ack  in  N_CH  per-channel acknowledge of pending event.
REQ-012 btn_level  out  N_CH  debounced stable level.
REQ-013 btn_press  out  N_CH  one-cycle pulse on accepted 0->1.
REQ-014 btn_release  out  N_CH  one-cycle pulse on accepted 1->0.
REQ-015 btn_repeat  out  N_CH  one-cycle auto-repeat pulse.
REQ-016 evt_pend  out  N_CH  sticky flag: press or repeat occurred, not yet acknowledged.

Function
REQ-017 Each channel SHALL pass btn_in through a two-flop synchroniser (sync1, sync2) before any other logic.
REQ-018 Debounce counter SHALL increment each enabled cycle sync2 != btn_level and clear to 0 on any cycle sync2 == btn_level.
REQ-019 When the counter equals DB_CYCLES-1 and mismatch persists, btn_level SHALL take sync2 and the counter SHALL clear at that edge.
REQ-020 btn_press/btn_release SHALL be registered and assert in the same cycle btn_level changes; latency from btn_in edge to pulse is DB_CYCLES+2 clock edges.
REQ-021 A glitch shorter than DB_CYCLES synchronised cycles SHALL produce no level change and no pulse.
REQ-022 Repeat counter SHALL clear on btn_press and count while btn_level=1 and rpt_en=1; state IDLE -> DELAY on press, DELAY -> RATE on first repeat, any -> IDLE on release.
REQ-023 First btn_repeat SHALL assert RPT_DELAY cycles after btn_press; subsequent pulses every RPT_RATE cycles while held.
REQ-024 rpt_en low SHALL hold the repeat counter and state, suppressing btn_repeat; re-raising resumes counting.
REQ-025 evt_pend SHALL set on btn_press or btn_repeat, clear on evt_ack; simultaneous set and ack SHALL leave evt_pend=1.
REQ-026 evt_ack with evt_pend=0 SHALL have no effect.
REQ-027 ena=0 SHALL hold synchronisers, counters, levels, state and evt_pend, and force all pulse outputs to 0.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-029 Counters SHALL never wrap; they saturate at their terminal values.

Reset
REQ-030 While rst_n=0 at a rising edge, sync1, sync2, btn_level, all counters, evt_pend and all pulse outputs SHALL clear to 0 and repeat state to IDLE.
REQ-031 Reset asserted mid-debounce or mid-repeat SHALL abort with no pulse; after release, a held button is re-qualified from zero.
REQ-032 Reset SHALL take priority over ena.

Verification (DB_CYCLES=4, RPT_DELAY=20, RPT_RATE=8, N_CH=2)
REQ-033 btn_in=01 held from edge 0 -> btn_press=01 for one cycle after edge 6, btn_level=01, evt_pend=01.
REQ-034 btn_in[0] pulse 3 cycles wide -> no btn_press, btn_level stays 00.
REQ-035 ch0 held, rpt_en=01 -> btn_repeat[0] at 20, 28, 36 cycles after press; release -> btn_release[0] pulse, repeats stop.
REQ-036 evt_ack[0] in the same cycle as btn_repeat[0] -> evt_pend[0] remains 1; ack one cycle later -> 0.
REQ-037 Both channels pressed together -> btn_press=11 in one cycle; ena=0 for 10 cycles mid-hold -> repeat timing shifted by exactly 10 cycles.
REQ-038 rst_n=0 for one edge during repeat DELAY with ch0 held -> all outputs 0; new btn_press[0] 6 edges after rst_n=1.
